// File: rtl/lcd_char_writer_if.sv
// rtl/lcd_char_writer_if.sv - character/instruction stream into lcd_char_writer
interface lcd_char_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       in_cmd;

    modport master (output in_valid, output in_char, output in_cmd, input in_ready);
    modport slave  (input in_valid, input in_char, input in_cmd, output in_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - 8-bit HD44780/ST7920 write-only driver with self-run init; LCD_AUTO_WRAP_EN adds line wrap
module lcd_char_writer #(
    parameter int          COLS           = 16,
    parameter int          ROWS           = 4,
    parameter logic [31:0] LINE_ADDRS     = 32'h98889080,
    parameter int          SETUP_CYC      = 4,
    parameter int          EN_HIGH_CYC    = 25,
    parameter int          HOLD_CYC       = 4,
    parameter int          CMD_WAIT_CYC   = 3600,
    parameter int          CLEAR_WAIT_CYC = 80000,
    parameter int          POWERUP_CYC    = 2000000
) (
    input  logic                clk,
    input  logic                rst,
    lcd_char_writer_if.slave    s,
    output logic                init_done,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_en,
    output logic [7:0]          lcd_dat
);
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, CMD_WAIT_CYC)),
                                  max2(CLEAR_WAIT_CYC, POWERUP_CYC));
    localparam int CW   = $clog2(MAX_CYC + 1);
    localparam int COLW = $clog2(COLS + 1);
    localparam logic [COLW-1:0] COL_END = COLW'(COLS);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, EN_HI, HOLD, WAIT} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, limit;
    logic [2:0]      init_idx, init_idx_n;
    logic            init_done_n, rs_n, is_clear, timer_done;
    logic [7:0]      dat_n;
    logic [1:0]      row, row_n, row_inc;
    logic [COLW-1:0] col, col_n;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    assign lcd_rw     = 1'b0;
    assign s.in_ready = (state == IDLE) && init_done;
    assign is_clear   = !lcd_rs && (lcd_dat == 8'h01 || lcd_dat == 8'h02);
    assign row_inc    = (row == 2'(ROWS - 1)) ? 2'd0 : row + 2'd1;

    // The counter counts cycles already spent in the current state; each timed state lasts limit+1 cycles.
    always_comb begin
        limit = '0;
        case (state)
            PWRUP:   limit = CW'(POWERUP_CYC - 1);
            SETUP:   limit = CW'(SETUP_CYC - 1);
            EN_HI:   limit = CW'(EN_HIGH_CYC - 1);
            HOLD:    limit = CW'(HOLD_CYC - 1);
            WAIT:    limit = is_clear ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
            default: limit = '0;
        endcase
    end

    assign timer_done = (cnt == limit);

    always_comb begin
        state_n     = state;
        cnt_n       = timer_done ? '0 : cnt + 1'b1;
        dat_n       = lcd_dat;
        rs_n        = lcd_rs;
        init_idx_n  = init_idx;
        init_done_n = init_done;
        row_n       = row;
        col_n       = col;
        case (state)
            PWRUP: if (timer_done) state_n = INIT;
            INIT: begin
                dat_n      = init_byte(init_idx);
                rs_n       = 1'b0;
                init_idx_n = init_idx + 3'd1;
                state_n    = SETUP;
            end
            IDLE: if (s.in_valid && s.in_ready) begin
                dat_n   = s.in_char;
                rs_n    = !s.in_cmd;
                state_n = SETUP;
            end
            SETUP: if (timer_done) state_n = EN_HI;
            EN_HI: if (timer_done) state_n = HOLD;
            HOLD:  if (timer_done) state_n = WAIT;
            WAIT: if (timer_done) begin
                if (lcd_rs) begin
                    if (col != COL_END) col_n = col + 1'b1;
                end else if (is_clear) begin
                    row_n = 2'd0;
                    col_n = '0;
                end else begin
                    for (int r = 0; r < 4; r++) begin
                        if (r < ROWS && lcd_dat == LINE_ADDRS[8*r +: 8]) begin
                            row_n = 2'(r);
                            col_n = '0;
                        end
                    end
                end
                if (!init_done) begin
                    if (init_idx == 3'd4) begin
                        init_done_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        state_n = INIT;
                    end
                end
`ifdef LCD_AUTO_WRAP_EN
                // Inserted cycle's address matches LINE_ADDRS, so its own completion moves the trackers.
                else if (lcd_rs && col_n == COL_END) begin
                    dat_n   = LINE_ADDRS[8*row_inc +: 8];
                    rs_n    = 1'b0;
                    state_n = SETUP;
                end
`endif
                else begin
                    state_n = IDLE;
                end
            end
            default: state_n = PWRUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWRUP;
            cnt       <= '0;
            lcd_dat   <= 8'h00;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            init_done <= 1'b0;
            init_idx  <= 3'd0;
            row       <= 2'd0;
            col       <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lcd_dat   <= dat_n;
            lcd_rs    <= rs_n;
            lcd_en    <= (state_n == EN_HI);
            init_done <= init_done_n;
            init_idx  <= init_idx_n;
            row       <= row_n;
            col       <= col_n;
        end
    end
endmodule

// File: tb/tb_lcd_char_writer.sv
// tb/tb_lcd_char_writer.sv - directed bench for lcd_char_writer (honours LCD_AUTO_WRAP_EN)
module tb_lcd_char_writer;
    logic       clk = 1'b0;
    logic       rst;
    logic       init_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_dat;

    lcd_char_writer_if bus ();

    lcd_char_writer #(
        .COLS(4), .ROWS(2), .LINE_ADDRS(32'h98889080),
        .SETUP_CYC(2), .EN_HIGH_CYC(3), .HOLD_CYC(2),
        .CMD_WAIT_CYC(10), .CLEAR_WAIT_CYC(40), .POWERUP_CYC(50)
    ) dut (
        .clk(clk), .rst(rst), .s(bus),
        .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .lcd_dat(lcd_dat)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_rise = 0;
    int wcnt = 0;
    logic en_prev = 1'b0;
    logic [8:0] pulses[$];
    int widths[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every enable pulse as {rs, dat} plus its high width.
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            pulses.push_back({lcd_rs, lcd_dat});
            last_rise = cyc;
            wcnt = 0;
        end
        if (lcd_en) wcnt++;
        else if (en_prev) widths.push_back(wcnt);
        en_prev = lcd_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pulses(input string tag, input logic [8:0] exp[$]);
        chk({tag, "_count"}, pulses.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pulses.size(); i++)
            chk(tag, {23'd0, pulses[i]}, {23'd0, exp[i]});
        pulses.delete();
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!bus.in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(t < 500), 32'd1);
    endtask

    task automatic wait_init(output int seen_cyc);
        int t = 0;
        while (!init_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        seen_cyc = cyc;
        chk("init_timeout", 32'(t < 3000), 32'd1);
    endtask

    task automatic send(input logic [7:0] c, input logic cmd);
        wait_ready("send_wait");
        bus.in_valid = 1'b1;
        bus.in_char  = c;
        bus.in_cmd   = cmd;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_cmd   = 1'b0;
    endtask

    initial begin
        logic [8:0] e[$];
        int done_cyc, s0, lo, t;
        int acc[3];

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        bus.in_cmd   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", lcd_en, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_dat", lcd_dat, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_ready", bus.in_ready, 0);

        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("pwrup_en_low", lcd_en, 0);
        chk("pwrup_no_pulse", pulses.size(), 0);
        wait_init(done_cyc);
        e = '{9'h038, 9'h00C, 9'h006, 9'h001};
        chk_pulses("init_seq", e);
        chk("init_width_n", widths.size(), 4);
        foreach (widths[i]) chk("init_width", widths[i], 3);
        // last rise -> init_done: EN_HIGH 3 + HOLD 2 + CLEAR_WAIT 40
        chk("init_done_lat", done_cyc - last_rise, 45);
        chk("init_ready", bus.in_ready, 1);

        bus.in_valid = 1'b1;
        bus.in_char  = 8'h41;
        bus.in_cmd   = 1'b0;
        @(negedge clk);
        s0 = cyc;
        bus.in_valid = 1'b0;
        chk("a_ready_low", bus.in_ready, 0);
        chk("a_rs", lcd_rs, 1);
        chk("a_dat", lcd_dat, 8'h41);
        chk("a_en_low", lcd_en, 0);
        lo = 0;
        while (!bus.in_ready && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        // ready low through SETUP 2 + EN 3 + HOLD 2 + WAIT 10; next accept 18 edges after this one
        chk("a_ready_gap", lo, 17);
        chk("a_setup_lead", last_rise - s0, 2);
        e = '{9'h141};
        chk_pulses("a_pulse", e);

        bus.in_valid = 1'b1;
        bus.in_char  = 8'h42;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!bus.in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("burst_wait", 32'(t < 200), 32'd1);
            acc[k] = cyc;
            @(negedge clk);
            chk("burst_ready_low", bus.in_ready, 0);
            if (k < 2) bus.in_char = 8'(8'h43 + k);
            else bus.in_valid = 1'b0;
        end
        chk("burst_period1", acc[1] - acc[0], 18);
        chk("burst_period2", acc[2] - acc[1], 18);
        wait_ready("burst_drain");
        e = '{9'h142, 9'h143, 9'h144};
`ifdef LCD_AUTO_WRAP_EN
        e.push_back(9'h090);
        chk("pre_clr_row", dut.row, 1);
        chk("pre_clr_col", dut.col, 0);
`else
        chk("pre_clr_row", dut.row, 0);
        chk("pre_clr_col", dut.col, 4);
`endif
        chk_pulses("burst_seq", e);

        bus.in_valid = 1'b1;
        bus.in_cmd   = 1'b1;
        bus.in_char  = 8'h01;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_cmd   = 1'b0;
        lo = 0;
        while (!bus.in_ready && lo < 200) begin
            lo++;
            @(negedge clk);
        end
        chk("clr_ready_gap", lo, 47);
        e = '{9'h001};
        chk_pulses("clr_pulse", e);
        chk("clr_row", dut.row, 0);
        chk("clr_col", dut.col, 0);

        for (int i = 0; i < 8; i++) send(8'(8'h45 + i), 1'b0);
        wait_ready("wrap_drain");
`ifdef LCD_AUTO_WRAP_EN
        e = '{9'h145, 9'h146, 9'h147, 9'h148, 9'h090, 9'h149, 9'h14A, 9'h14B, 9'h14C, 9'h080};
        chk("wrap_col", dut.col, 0);
`else
        e = '{9'h145, 9'h146, 9'h147, 9'h148, 9'h149, 9'h14A, 9'h14B, 9'h14C};
        chk("wrap_col", dut.col, 4);
`endif
        chk("wrap_row", dut.row, 0);
        chk_pulses("wrap_seq", e);

        send(8'h5A, 1'b0);
        t = 0;
        while (!lcd_en && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_en_wait", 32'(t < 100), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", lcd_en, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_ready", bus.in_ready, 0);
        chk("mid_rst_dat", lcd_dat, 0);
        rst = 1'b0;
        pulses.delete();
        widths.delete();
        repeat (50) @(negedge clk);
        chk("re_pwrup_no_pulse", pulses.size(), 0);
        wait_init(done_cyc);
        e = '{9'h038, 9'h00C, 9'h006, 9'h001};
        chk_pulses("re_init_seq", e);
        chk("re_init_ready", bus.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
